// File: rtl/pad_cmd_scheduler_if.sv
// Handshake/bus bundle for pad_cmd_scheduler.
// The master side drives the pad ticks and the consumer controls; the slave side is the scheduler.
interface pad_cmd_scheduler_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          pad_Sd;
    logic          pad_Rd;
    logic          pad_Ld;
    logic          pad_Dd;
    logic          bttn_Dd;
    logic          enable;
    logic          cmd_ready;
    logic          ovf_clr;
    logic          cmd_valid;
    logic [2:0]    cmd_code;
    logic [LW-1:0] fifo_level;
    logic          ovf;

    modport master (
        output pad_Sd, pad_Rd, pad_Ld, pad_Dd, bttn_Dd,
        output enable, cmd_ready, ovf_clr,
        input  cmd_valid, cmd_code, fifo_level, ovf
    );

    modport slave (
        input  pad_Sd, pad_Rd, pad_Ld, pad_Dd, bttn_Dd,
        input  enable, cmd_ready, ovf_clr,
        output cmd_valid, cmd_code, fifo_level, ovf
    );
endinterface

// File: rtl/pad_cmd_scheduler.sv
// Round-robin arbiter for five debounced tick sources feeding a small command FIFO.
// Optional macro PAD_SCHED_COALESCE_EN drops a grant that repeats the newest queued code.
module pad_cmd_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   pclk,
    input  logic                   rst,
    pad_cmd_scheduler_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned NSRC = 5;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [NSRC-1:0] pending_q, pending_d;
    logic [2:0]      last_q, last_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      mem_q [DEPTH];

    logic [NSRC-1:0] tick;
    logic [NSRC-1:0] grant_mask;
    logic            grant_vld;
    logic [2:0]      grant_idx;
    logic [2:0]      grant_code;
    logic            coalesce;
    logic            push;
    logic            pop;

    assign tick = {bus.bttn_Dd, bus.pad_Dd, bus.pad_Ld, bus.pad_Rd, bus.pad_Sd};

    // Search begins one past the last winner; full is judged on the registered level only.
    always_comb begin
        int unsigned idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_mask = '0;
        idx        = 0;
        if (bus.enable && (level_q != FULL_LVL)) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                idx = (int'(last_q) + 1 + i) % NSRC;
                if (!grant_vld && pending_q[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = 3'(idx);
                end
            end
        end
        if (grant_vld) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    assign grant_code = grant_idx + 3'd1;

`ifdef PAD_SCHED_COALESCE_EN
    // Newest entry sits just behind the write pointer; pops this cycle do not affect it.
    assign coalesce = grant_vld && (level_q != '0) && (mem_q[wr_ptr_q - 1'b1] == grant_code);
`else
    assign coalesce = 1'b0;
`endif

    assign push = grant_vld && !coalesce;
    assign pop  = (level_q != '0) && bus.cmd_ready;

    always_comb begin
        pending_d = '0;
        last_d    = last_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;

        if (bus.enable) begin
            pending_d = (pending_q & ~grant_mask) | tick;
        end
        if (grant_vld) begin
            last_d = grant_idx;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(push) - LW'(pop);

        // A repeat tick on a still-pending, ungranted source is the only loss path.
        if (bus.enable && ((tick & pending_q & ~grant_mask) != '0)) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            last_q    <= 3'd4;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= grant_code;
            end
        end
    end

    assign bus.cmd_valid  = (level_q != '0);
    assign bus.cmd_code   = (level_q != '0) ? mem_q[rd_ptr_q] : 3'd0;
    assign bus.fifo_level = level_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_pad_cmd_scheduler.sv
// Directed bench for pad_cmd_scheduler (DEPTH=4); inputs change and outputs are sampled 1ns after each rising edge.
module tb_pad_cmd_scheduler;
    logic pclk;
    logic rst;
    int unsigned n_tests;
    int unsigned n_fail;

    pad_cmd_scheduler_if #(.DEPTH(4)) bus ();

    pad_cmd_scheduler #(.DEPTH(4)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_ticks(input logic [4:0] v);
        bus.pad_Sd  = v[0];
        bus.pad_Rd  = v[1];
        bus.pad_Ld  = v[2];
        bus.pad_Dd  = v[3];
        bus.bttn_Dd = v[4];
    endtask

    task automatic pulse(input logic [4:0] v);
        set_ticks(v);
        step();
        set_ticks(5'b0);
    endtask

    task automatic do_reset();
        set_ticks(5'b0);
        bus.enable    = 1'b1;
        bus.cmd_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned seq5 [5];
        int unsigned seq_ovf [5];
        n_tests = 0;
        n_fail  = 0;
        seq5    = '{1, 2, 3, 4, 5};
        seq_ovf = '{2, 3, 4, 5, 1};

        // Reset values
        do_reset();
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_code", bus.cmd_code, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_ovf", bus.ovf, 0);

        // Single L tick: valid exactly two cycles later for one cycle
        bus.cmd_ready = 1'b1;
        pulse(5'b00100);
        check("l_lat1_valid", bus.cmd_valid, 0);
        step();
        check("l_lat2_valid", bus.cmd_valid, 1);
        check("l_code", bus.cmd_code, 3);
        check("l_level", bus.fifo_level, 1);
        step();
        check("l_after_valid", bus.cmd_valid, 0);
        check("l_after_code", bus.cmd_code, 0);
        check("l_after_level", bus.fifo_level, 0);

        // All five ticks at once: round-robin order from source 0
        do_reset();
        bus.cmd_ready = 1'b1;
        pulse(5'b11111);
        check("all5_lat_valid", bus.cmd_valid, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("all5_valid%0d", k), bus.cmd_valid, 1);
            check($sformatf("all5_code%0d", k), bus.cmd_code, seq5[k]);
            step();
        end
        check("all5_empty", bus.cmd_valid, 0);

        // Separate ticks with consumer stalled: FIFO fills, B waits pending
        do_reset();
        pulse(5'b00001);
        pulse(5'b00010);
        pulse(5'b00100);
        pulse(5'b01000);
        pulse(5'b10000);
        step();
        check("fill_level", bus.fifo_level, 4);
        step();
        check("fill_level_hold", bus.fifo_level, 4);
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fill_code%0d", k), bus.cmd_code, seq5[k]);
            step();
        end
        check("fill_empty", bus.cmd_valid, 0);
        check("fill_ovf", bus.ovf, 0);

        // Repeat S tick while S pending and FIFO full: ovf, single code 1
        do_reset();
        pulse(5'b00010);
        pulse(5'b00100);
        pulse(5'b01000);
        pulse(5'b10000);
        pulse(5'b00001);
        check("ovf_pre", bus.ovf, 0);
        check("ovf_full", bus.fifo_level, 4);
        pulse(5'b00001);
        check("ovf_set", bus.ovf, 1);
        step();
        check("ovf_sticky", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", bus.ovf, 0);
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ovf_code%0d", k), bus.cmd_code, seq_ovf[k]);
            step();
        end
        check("ovf_empty", bus.cmd_valid, 0);

        // Ticks ignored while disabled; disabling drops pending but FIFO drains
        do_reset();
        bus.enable = 1'b0;
        pulse(5'b00010);
        step();
        step();
        check("dis_level", bus.fifo_level, 0);
        check("dis_valid", bus.cmd_valid, 0);
        bus.enable = 1'b1;
        pulse(5'b00001);
        pulse(5'b00010);
        pulse(5'b00100);
        pulse(5'b01000);
        pulse(5'b00010);
        check("dis_full", bus.fifo_level, 4);
        bus.enable    = 1'b0;
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dis_code%0d", k), bus.cmd_code, seq5[k]);
            step();
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dis_idle%0d", k), bus.cmd_valid, 0);
            step();
        end
        check("dis_ovf", bus.ovf, 0);

        // Two D ticks five cycles apart, consumer stalled
        do_reset();
        pulse(5'b01000);
        for (int k = 0; k < 4; k++) step();
        pulse(5'b01000);
        for (int k = 0; k < 3; k++) step();
`ifdef PAD_SCHED_COALESCE_EN
        check("coal_level", bus.fifo_level, 1);
`else
        check("coal_level", bus.fifo_level, 2);
`endif
        check("coal_code", bus.cmd_code, 4);
        check("coal_ovf", bus.ovf, 0);

        // Asynchronous reset mid-operation discards everything immediately
        pulse(5'b00001);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_level", bus.fifo_level, 0);
        check("mid_rst_valid", bus.cmd_valid, 0);
        check("mid_rst_code", bus.cmd_code, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("mid_rst_idle", bus.cmd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pad_cmd_scheduler.md
# pad_cmd_scheduler

Sits between `debouncer` and the game logic. Collects the one-cycle debounced pulses from the pad (S, R, L, D) and the board button (D), and arbitrates between them round-robin. Buffers the resulting command codes in a small FIFO and presents them to the game logic one at a time over a valid/ready handshake. No press is lost unless the same source fires again before its previous press is arbitrated; any such loss is flagged.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- pclk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pad_Sd  in  1  debounced pad S tick, 1-cycle pulse (source 0)
- pad_Rd  in  1  debounced pad R tick (source 1)
- pad_Ld  in  1  debounced pad L tick (source 2)
- pad_Dd  in  1  debounced pad D tick (source 3)
- bttn_Dd  in  1  debounced board button tick (source 4)
- enable  in  1  accept new ticks when 1
- cmd_ready  in  1  game logic consumes head command this cycle
- ovf_clr  in  1  clears ovf
- cmd_valid  out  1  FIFO non-empty
- cmd_code  out  3  head command: source index + 1 (1..5); 0 when cmd_valid=0
- fifo_level  out  clog2(DEPTH)+1  entries held
- ovf  out  1  sticky lost-tick flag

## Operation
- **Pending register** (5 bits):
  - A tick with enable=1 sets its bit.
  - A bit clears when that source is granted.
  - With enable=0, all bits clear and ticks are ignored. The FIFO keeps draining.
- **Grant**:
  - One grant per cycle, only if a pending bit is set and fifo_level < DEPTH.
  - Full is judged on the registered level. A pop in the same cycle does not free a slot until the next cycle.
- **Round-robin pointer** `last` (0..4):
  - The search starts at last+1 mod 5. The first pending bit found is granted.
  - `last` updates to the granted index.
  - Reset value 4, so source 0 (S) has first priority.
- **Push**: code (index+1) is written at the tail; the write pointer wraps mod DEPTH.
- **Pop**: on cmd_valid && cmd_ready; the read pointer wraps mod DEPTH. cmd_ready with cmd_valid=0 is ignored.
- **Simultaneous push and pop**: allowed whenever a grant is legal; fifo_level is unchanged.
- **Overflow**:
  - ovf sets when a tick arrives (enable=1) for a source whose pending bit is already set and is not granted that cycle. That tick is discarded.
  - A tick arriving in the same cycle its bit is granted re-sets the bit. It is not lost.
  - ovf_clr clears ovf. If ovf_clr and a set condition occur in the same cycle, set wins.
- **FIFO full**: pending bits hold indefinitely. The only loss path is a repeat tick, as above.
- **Reset mid-operation**: FIFO contents, pointers, pending and ovf are all discarded immediately.

## Timing
- Reset values:
  - cmd_valid=0, cmd_code=0, fifo_level=0, ovf=0
  - pending=0, last=4, read/write pointers=0
- Latency, uncontended tick into an empty FIFO:
  - Tick at cycle N → pending bit set after edge N.
  - Granted and pushed at edge N+1.
  - cmd_valid=1 with the code during cycle N+2.
- cmd_code and cmd_valid are driven from registers only; no combinational path from cmd_ready.
- Each subsequent command appears the cycle after the pop edge, provided the FIFO holds more entries.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- PAD_SCHED_COALESCE_EN
  - **Defined**: a grant whose code equals the most recently pushed entry, while that entry is still in the FIFO (fifo_level>0, before any pop that cycle), clears the pending bit with no push. `last` still updates. This collapses repeated presses such as a held-and-retapped D.
  - **Undefined**: every grant pushes.
  - In both modes, coalescing never sets ovf.

## Test plan
- After reset, a single pad_Ld pulse with cmd_ready=1 → cmd_valid high exactly 2 cycles later with cmd_code=3 for 1 cycle; fifo_level returns to 0.
- All five ticks in one cycle, cmd_ready=1, after reset → codes 1,2,3,4,5 on consecutive cycles.
- With cmd_ready=0 and DEPTH=4, ticks S,R,L,D,B on separate cycles → fifo_level=4 and B stays pending. Then cmd_ready=1 → output 1,2,3,4,5; ovf=0.
- FIFO full and pad_Sd pending, a second pad_Sd pulse → ovf=1 and only one code 1 is output. ovf_clr then drops ovf on the next edge.
- enable=0 during a pad_Rd pulse → nothing queued. enable=0 with R pending → pending cleared; FIFO entries still drain.
- With the macro defined, cmd_ready=0, two pad_Dd pulses 5 cycles apart → fifo_level=1, one code 4. Without the macro → fifo_level=2.
